// File: rtl/y86_pipe_ctrl.sv
// Pipeline control and status unit for the five-stage Y86-64 core: hazard stall/bubble
// generation, the RUN/HALT/FAULT run-state machine, a cycle watchdog and saturating counters.
module y86_pipe_ctrl #(
  parameter int         CNT_W    = 64,
  parameter int         MAX_CYC  = 4096,
  parameter logic [3:0] STAT_TMO = 4'h5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       m_stat,
  input  logic [3:0]       W_stat,
  input  logic             W_valid,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             set_cc,
  output logic [1:0]       run_state,
  output logic [3:0]       proc_stat,
  output logic             done,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] S_AOK    = 4'h1;
  localparam logic [3:0] S_HLT    = 4'h2;
  localparam logic [3:0] S_ADR    = 4'h3;
  localparam logic [3:0] S_INS    = 4'h4;

  localparam bit               WD_EN   = (MAX_CYC != 0);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_CYC - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } run_state_t;

  run_state_t       state_q, state_d;
  logic [3:0]       stat_q, stat_d;
  logic [CNT_W-1:0] cyc_q, ins_q, stl_q, mp_q;

  logic lu, ret_h, mp, exc, is_run, retire;

  assign lu = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) && (E_dstM != REG_NONE) &&
              ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign ret_h  = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
  assign mp     = (E_icode == I_JXX) && !e_Cnd;
  assign exc    = (m_stat != S_AOK) || (W_stat != S_AOK);
  assign is_run = (state_q == ST_RUN);
  assign retire = W_valid && (W_stat == S_AOK);

  // Once stopped the pipe is frozen with nops behind the stalled stages.
  always_comb begin
    F_stall  = 1'b1;
    D_stall  = 1'b1;
    D_bubble = 1'b0;
    E_bubble = 1'b1;
    M_bubble = 1'b1;
    W_stall  = 1'b1;
    set_cc   = 1'b0;
    if (is_run) begin
      F_stall  = lu | ret_h;
      D_stall  = lu;
      D_bubble = mp | (ret_h & ~lu);
      E_bubble = mp | lu;
      M_bubble = exc;
      W_stall  = (W_stat != S_AOK);
      set_cc   = (E_icode == I_OPQ) && !exc;
    end
  end

  // A retiring halt/fault outranks a watchdog expiry in the same cycle.
  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    if (is_run) begin
      if (W_valid && (W_stat != S_AOK)) begin
        case (W_stat)
          S_HLT: begin
            state_d = ST_HALT;
            stat_d  = S_HLT;
          end
          S_ADR, S_INS: begin
            state_d = ST_FAULT;
            stat_d  = W_stat;
          end
          default: begin
            state_d = ST_FAULT;
            stat_d  = S_INS;
          end
        endcase
      end else if (WD_EN && (cyc_q == WD_LAST)) begin
        state_d = ST_FAULT;
        stat_d  = STAT_TMO;
      end
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      stat_q  <= S_AOK;
      cyc_q   <= '0;
      ins_q   <= '0;
      stl_q   <= '0;
      mp_q    <= '0;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
      if (is_run) begin
        cyc_q <= sat_inc(cyc_q, 1'b1);
        ins_q <= sat_inc(ins_q, retire);
        stl_q <= sat_inc(stl_q, lu);
        mp_q  <= sat_inc(mp_q, mp);
      end
    end
  end

  assign run_state   = state_q;
  assign proc_stat   = stat_q;
  assign done        = (state_q != ST_RUN);
  assign cycle_cnt   = cyc_q;
  assign instr_cnt   = ins_q;
  assign stall_cnt   = stl_q;
  assign mispred_cnt = mp_q;

endmodule

// File: tb/tb_y86_pipe_ctrl.sv
// Bench for y86_pipe_ctrl: two parameterisations share one directed input stream and are
// checked every cycle against a behavioural model, plus hand-computed literal checks.
module tb_y86_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, m_stat, W_stat;
  logic       e_Cnd, W_valid;

  // Instance a: CNT_W=4, watchdog off. Instance b: CNT_W=16, MAX_CYC=8.
  logic        a_fs, a_ds, a_db, a_eb, a_mb, a_ws, a_cc, a_done;
  logic [1:0]  a_rs;
  logic [3:0]  a_ps;
  logic [3:0]  a_cyc, a_ins, a_stl, a_mp;
  logic        b_fs, b_ds, b_db, b_eb, b_mb, b_ws, b_cc, b_done;
  logic [1:0]  b_rs;
  logic [3:0]  b_ps;
  logic [15:0] b_cyc, b_ins, b_stl, b_mp;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  y86_pipe_ctrl #(.CNT_W(4), .MAX_CYC(0), .STAT_TMO(4'h5)) dut_a (
    .clk(clk), .rst_n(rst_n), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode), .m_stat(m_stat),
    .W_stat(W_stat), .W_valid(W_valid), .F_stall(a_fs), .D_stall(a_ds), .D_bubble(a_db),
    .E_bubble(a_eb), .M_bubble(a_mb), .W_stall(a_ws), .set_cc(a_cc), .run_state(a_rs),
    .proc_stat(a_ps), .done(a_done), .cycle_cnt(a_cyc), .instr_cnt(a_ins),
    .stall_cnt(a_stl), .mispred_cnt(a_mp)
  );

  y86_pipe_ctrl #(.CNT_W(16), .MAX_CYC(8), .STAT_TMO(4'h5)) dut_b (
    .clk(clk), .rst_n(rst_n), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode), .m_stat(m_stat),
    .W_stat(W_stat), .W_valid(W_valid), .F_stall(b_fs), .D_stall(b_ds), .D_bubble(b_db),
    .E_bubble(b_eb), .M_bubble(b_mb), .W_stall(b_ws), .set_cc(b_cc), .run_state(b_rs),
    .proc_stat(b_ps), .done(b_done), .cycle_cnt(b_cyc), .instr_cnt(b_ins),
    .stall_cnt(b_stl), .mispred_cnt(b_mp)
  );

  // Model state: run state 0/1/2, status, counters {cycle, instr, stall, mispred}.
  int     m_st[2]    = '{0, 0};
  int     m_ps[2]    = '{1, 1};
  longint m_c[2][4];
  longint cap[2]     = '{15, 65535};
  longint wd[2]      = '{0, 8};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit lu_f();
    return (E_icode == 4'h5 || E_icode == 4'hB) && E_dstM != 4'hF &&
           (E_dstM == d_srcA || E_dstM == d_srcB);
  endfunction

  function automatic bit mp_f();
    return E_icode == 4'h7 && !e_Cnd;
  endfunction

  // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc}
  function automatic logic [6:0] exp_ctl(input int st);
    bit lu, rt, mp, exc;
    if (st != 0) return 7'b1101110;
    lu  = lu_f();
    mp  = mp_f();
    rt  = D_icode == 4'h9 || E_icode == 4'h9 || M_icode == 4'h9;
    exc = m_stat != 4'h1 || W_stat != 4'h1;
    return {lu | rt, lu, mp | (rt & !lu), mp | lu, exc, W_stat != 4'h1,
            E_icode == 4'h6 && !exc};
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_st[i] = 0;
        m_ps[i] = 1;
        for (int k = 0; k < 4; k++) m_c[i][k] = 0;
      end else if (m_st[i] == 0) begin
        if (W_valid && W_stat != 4'h1) begin
          if (W_stat == 4'h2) begin m_st[i] = 1; m_ps[i] = 2; end
          else if (W_stat == 4'h3 || W_stat == 4'h4) begin m_st[i] = 2; m_ps[i] = int'(W_stat); end
          else begin m_st[i] = 2; m_ps[i] = 4; end
        end else if (wd[i] != 0 && m_c[i][0] == wd[i] - 1) begin
          m_st[i] = 2;
          m_ps[i] = 5;
        end
        if (m_c[i][0] < cap[i]) m_c[i][0]++;
        if (W_valid && W_stat == 4'h1 && m_c[i][1] < cap[i]) m_c[i][1]++;
        if (lu_f() && m_c[i][2] < cap[i]) m_c[i][2]++;
        if (mp_f() && m_c[i][3] < cap[i]) m_c[i][3]++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_ctl", {a_fs, a_ds, a_db, a_eb, a_mb, a_ws, a_cc}, exp_ctl(m_st[0]));
      chk("a_run_state", a_rs, m_st[0]);
      chk("a_proc_stat", a_ps, m_ps[0]);
      chk("a_done", a_done, m_st[0] != 0);
      chk("a_cycle_cnt", a_cyc, m_c[0][0]);
      chk("a_instr_cnt", a_ins, m_c[0][1]);
      chk("a_stall_cnt", a_stl, m_c[0][2]);
      chk("a_mispred_cnt", a_mp, m_c[0][3]);
      chk("b_ctl", {b_fs, b_ds, b_db, b_eb, b_mb, b_ws, b_cc}, exp_ctl(m_st[1]));
      chk("b_run_state", b_rs, m_st[1]);
      chk("b_proc_stat", b_ps, m_ps[1]);
      chk("b_done", b_done, m_st[1] != 0);
      chk("b_cycle_cnt", b_cyc, m_c[1][0]);
      chk("b_instr_cnt", b_ins, m_c[1][1]);
      chk("b_stall_cnt", b_stl, m_c[1][2]);
      chk("b_mispred_cnt", b_mp, m_c[1][3]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neutral();
    D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF; E_icode = 4'h1; E_dstM = 4'hF;
    e_Cnd = 1'b1; M_icode = 4'h1; m_stat = 4'h1; W_stat = 4'h1; W_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL time_limit: simulation exceeded its time budget");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = 1'b0;
    neutral();
    step();
    step();
    chk_en = 1'b1;
    chk("rst_run_state", a_rs, 0);
    chk("rst_proc_stat", a_ps, 1);
    chk("rst_instr_cnt", a_ins, 0);
    chk("rst_done", a_done, 0);
    rst_n = 1'b1;

    // Load/use: mrmovq into r3 while decode reads r3
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3; #1;
    chk("lu_F_stall", a_fs, 1); chk("lu_D_stall", a_ds, 1);
    chk("lu_E_bubble", a_eb, 1); chk("lu_D_bubble", a_db, 0);
    step();
    neutral(); E_icode = 4'h7; e_Cnd = 1'b0; #1;
    chk("mp_D_bubble", a_db, 1); chk("mp_E_bubble", a_eb, 1); chk("mp_F_stall", a_fs, 0);
    step();
    neutral(); D_icode = 4'h9; E_icode = 4'h5; E_dstM = 4'h3; d_srcB = 4'h3; #1;
    chk("retlu_D_bubble", a_db, 0); chk("retlu_D_stall", a_ds, 1); chk("retlu_F_stall", a_fs, 1);
    step();
    neutral(); D_icode = 4'h9; #1;
    chk("ret_F_stall", a_fs, 1); chk("ret_D_bubble", a_db, 1); chk("ret_D_stall", a_ds, 0);
    step();
    neutral(); E_icode = 4'h7; e_Cnd = 1'b0; M_icode = 4'h9; #1;
    chk("mpret_D_bubble", a_db, 1); chk("mpret_E_bubble", a_eb, 1);
    step();
    neutral(); E_icode = 4'h6; #1;
    chk("opq_set_cc", a_cc, 1);
    step();
    neutral(); E_icode = 4'h6; m_stat = 4'h3; #1;
    chk("opq_exc_set_cc", a_cc, 0); chk("exc_M_bubble", a_mb, 1); chk("exc_W_stall", a_ws, 0);
    step();
    chk("hz_stall_cnt", a_stl, 2); chk("hz_mispred_cnt", a_mp, 2); chk("hz_cycle_cnt", a_cyc, 7);

    // Eighth RUN cycle trips instance b's watchdog
    neutral();
    step();
    chk("wd_run_state", b_rs, 2); chk("wd_proc_stat", b_ps, 5);
    chk("wd_cycle_cnt", b_cyc, 8); chk("wd_done", b_done, 1); chk("wd_a_running", a_rs, 0);

    // Ten retirements then a halt on instance a
    W_valid = 1'b1;
    for (int i = 0; i < 10; i++) step();
    W_stat = 4'h2;
    step();
    chk("halt_run_state", a_rs, 1); chk("halt_proc_stat", a_ps, 2);
    chk("halt_done", a_done, 1); chk("halt_instr_cnt", a_ins, 10); chk("halt_cycle_cnt", a_cyc, 15);

    // Frozen while halted despite retire/load-use inputs
    neutral(); W_valid = 1'b1; E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
    for (int i = 0; i < 3; i++) step();
    chk("frz_instr_cnt", a_ins, 10); chk("frz_stall_cnt", a_stl, 2);
    chk("frz_F_stall", a_fs, 1); chk("frz_D_bubble", a_db, 0); chk("frz_E_bubble", a_eb, 1);
    chk("frz_M_bubble", a_mb, 1); chk("frz_W_stall", a_ws, 1); chk("frz_set_cc", a_cc, 0);

    rst_n = 1'b0;
    step();
    chk("rst2_run_state", a_rs, 0); chk("rst2_proc_stat", a_ps, 1);
    chk("rst2_instr_cnt", a_ins, 0); chk("rst2_cycle_cnt", a_cyc, 0); chk("rst2_stall_cnt", a_stl, 0);
    chk("rst2_b_run_state", b_rs, 0); chk("rst2_b_cycle_cnt", b_cyc, 0);
    rst_n = 1'b1;

    // Saturation: 20 retirements on a 4-bit counter
    neutral(); W_valid = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("sat_instr_cnt", a_ins, 15); chk("sat_cycle_cnt", a_cyc, 15);
    W_stat = 4'h3;
    step();
    chk("adr_run_state", a_rs, 2); chk("adr_proc_stat", a_ps, 3); chk("adr_instr_cnt", a_ins, 15);

    // Halt coinciding with the watchdog's last cycle: halt wins
    rst_n = 1'b0; neutral();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) step();
    W_valid = 1'b1; W_stat = 4'h2;
    step();
    chk("race_run_state", b_rs, 1); chk("race_proc_stat", b_ps, 2); chk("race_cycle_cnt", b_cyc, 8);

    // Bad status without W_valid does not stop; an unknown code with W_valid faults as INS
    rst_n = 1'b0; neutral();
    step();
    rst_n = 1'b1;
    W_stat = 4'h3;
    step();
    chk("nov_run_state", a_rs, 0); chk("nov_W_stall", a_ws, 1);
    W_stat = 4'h7; W_valid = 1'b1;
    step();
    chk("bad_run_state", a_rs, 2); chk("bad_proc_stat", a_ps, 4);
    neutral();
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
